cbus_arbiter: RTL



---
 rtl/cbus_arbiter_pkg.sv | 30 +++
 rtl/cbus_arbiter_picker.sv | 34 +++
 rtl/cbus_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/cbus_arbiter_pkg.sv
// CBus request/response types and the arbiter's state, beat-count and pointer helpers.
package cbus_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int CBUS_MAX_BEATS = 16;
  // One spare bit so a full 16-beat burst never wraps the counter.
  localparam int BEAT_W = $clog2(CBUS_MAX_BEATS) + 1;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_picker.sv
// Combinational winner select: rotating priority from rr_ptr, or fixed lowest-index-wins.
module cbus_arbiter_picker #(
  parameter int NUM_REQ     = 2,
  parameter int ROUND_ROBIN = 1,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  // pos[k] is the requester examined k-th in priority order.
  logic [IDX_W-1:0] pos [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pos
      if (ROUND_ROBIN != 0) begin : g_rr
        assign pos[gi] = IDX_W'((int'(rr_ptr) + gi) % NUM_REQ);
      end else begin : g_fixed
        assign pos[gi] = IDX_W'(gi);
      end
    end
  endgenerate

  always_comb begin
    winner    = '0;
    any_valid = |valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[pos[k]]) winner = pos[k];
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one CBus master port among NUM_REQ requesters; grant is held for a whole burst.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ROUND_ROBIN = 1,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] req_valid;
  logic [IDX_W-1:0]   winner;
  logic               any_valid;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
      assign req_valid[gi] = ireqs[gi].valid;
    end
  endgenerate

  cbus_arbiter_picker #(
    .NUM_REQ     (NUM_REQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = BUSY;
          sel_d      = winner;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (oresp.ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (oresp.last) begin
            state_d = IDLE;
            if (ROUND_ROBIN != 0) rr_ptr_d = IDX_W'(wrap_inc(int'(sel_q), NUM_REQ));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Request and response paths are pure muxes once granted: no added latency.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_REQ; i++) iresps[i] = '0;
    if (state_q == BUSY) begin
      oreq          = ireqs[sel_q];
      iresps[sel_q] = oresp;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = sel_q;

  always @(posedge clk) begin
    if (resetn) begin
      if (state_q == IDLE) assert (!oresp.ready);
      if (state_q == BUSY) begin
        assert (ireqs[sel_q].valid);
        if (oresp.ready && oresp.last) assert (beat_cnt_q == BEAT_W'(ireqs[sel_q].len));
      end
    end
  end

endmodule
